// File: rtl/nes_pkg.sv
// rtl/nes_pkg.sv - shared types and constants for the NES controller reader
package nes_pkg;

  typedef enum logic [1:0] {IDLE, LATCH, SAMPLE, PULSE} nes_state_t;

  localparam int NES_NUM_BITS = 8;

  // Position of each button in the serial stream and in the button vector
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/rising_edge_detect.sv
// rtl/rising_edge_detect.sv - one-cycle strobe on each rising edge of a same-domain level
module rising_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic in,
  output logic pulse
);

  logic prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev_q <= 1'b0;
    else          prev_q <= in;
  end

  assign pulse = in & ~prev_q;

endmodule

// File: rtl/nes_controller_reader.sv
// rtl/nes_controller_reader.sv - polls a NES controller over latch/clock/data and
// presents a registered active-high button vector
module nes_controller_reader
  import nes_pkg::*;
#(
  parameter int NUM_BITS    = NES_NUM_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clock_10MHz,
  input  logic                reset_n,
  input  logic                poll_clk,
  input  logic                step_clk,
  input  logic                nes_data,
  output logic                nes_latch,
  output logic                nes_clk,
  output logic [NUM_BITS-1:0] buttons,
  output logic                buttons_valid,
  output logic                busy,
  output logic                poll_overrun
);

  localparam int IDX_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BITS - 1);

  logic poll_edge;
  logic step_edge;

  rising_edge_detect u_poll_edge (
    .clk     (clock_10MHz),
    .reset_n (reset_n),
    .in      (poll_clk),
    .pulse   (poll_edge)
  );

  rising_edge_detect u_step_edge (
    .clk     (clock_10MHz),
    .reset_n (reset_n),
    .in      (step_clk),
    .pulse   (step_edge)
  );

  // Synchronizer resets to the released (high) level of the data line
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   data_sync;

  always_ff @(posedge clock_10MHz or negedge reset_n) begin
    if (!reset_n) sync_q <= '1;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], nes_data};
  end

  assign data_sync = sync_q[SYNC_STAGES-1];

  nes_state_t          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_BITS-1:0] shreg_q, shreg_d;
  logic [NUM_BITS-1:0] buttons_q, buttons_d;
  logic                latch_q, latch_d;
  logic                clk_q, clk_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic                pending_q, pending_d;
  logic                overrun_q, overrun_d;
  logic                consume;

  always_ff @(posedge clock_10MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      shreg_q   <= '0;
      buttons_q <= '0;
      latch_q   <= 1'b0;
      clk_q     <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      buttons_q <= buttons_d;
      latch_q   <= latch_d;
      clk_q     <= clk_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    buttons_d = buttons_q;
    latch_d   = latch_q;
    clk_d     = clk_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;

    // A request arriving on the consuming cycle survives as the next pending read
    consume   = (state_q == IDLE) & step_edge & pending_q;
    pending_d = (pending_q & ~consume) | poll_edge;
    overrun_d = poll_edge & pending_q & ~consume;

    if (step_edge) begin
      case (state_q)
        IDLE: begin
          if (pending_q) begin
            state_d = LATCH;
            latch_d = 1'b1;
            busy_d  = 1'b1;
          end
        end
        LATCH: begin
          latch_d = 1'b0;
          idx_d   = '0;
          state_d = SAMPLE;
        end
        SAMPLE: begin
          shreg_d[idx_q] = ~data_sync;
          clk_d          = 1'b1;
          state_d        = PULSE;
        end
        PULSE: begin
          clk_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            buttons_d = shreg_q;
            valid_d   = 1'b1;
            busy_d    = 1'b0;
            state_d   = IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = SAMPLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign nes_latch     = latch_q;
  assign nes_clk       = clk_q;
  assign buttons       = buttons_q;
  assign buttons_valid = valid_q;
  assign busy          = busy_q;
  assign poll_overrun  = overrun_q;

endmodule

// File: tb/tb_nes_controller_reader.sv
// tb/tb_nes_controller_reader.sv - directed bench for nes_controller_reader with a
// behavioural controller model on the serial pins
`timescale 1ns/1ps
module tb_nes_controller_reader;

  logic       clock_10MHz = 1'b0;
  logic       reset_n     = 1'b0;
  logic       poll_clk    = 1'b0;
  logic       step_clk    = 1'b0;
  logic       nes_data;
  logic       nes_latch;
  logic       nes_clk;
  logic [7:0] buttons;
  logic       buttons_valid;
  logic       busy;
  logic       poll_overrun;

  nes_controller_reader #(.NUM_BITS(8), .SYNC_STAGES(2)) dut (
    .clock_10MHz   (clock_10MHz),
    .reset_n       (reset_n),
    .poll_clk      (poll_clk),
    .step_clk      (step_clk),
    .nes_data      (nes_data),
    .nes_latch     (nes_latch),
    .nes_clk       (nes_clk),
    .buttons       (buttons),
    .buttons_valid (buttons_valid),
    .busy          (busy),
    .poll_overrun  (poll_overrun)
  );

  always #50 clock_10MHz = ~clock_10MHz;

  // Step tap: 128-cycle period, frozen while step_run is low
  logic       step_run = 1'b1;
  logic [6:0] step_cnt = '0;
  always @(negedge clock_10MHz) begin
    if (step_run) begin
      step_cnt = step_cnt + 7'd1;
      step_clk = step_cnt[6];
    end
  end

  // Controller model: parallel load while latched, shift on nes_clk rise, active-low out
  logic [7:0] pattern = 8'h00;
  logic [7:0] ctrl_sr = 8'hFF;
  logic       ctrl_clk_prev = 1'b0;
  always @(negedge clock_10MHz) begin
    if (nes_latch)                     ctrl_sr = ~pattern;
    else if (nes_clk && !ctrl_clk_prev) ctrl_sr = {1'b1, ctrl_sr[7:1]};
    ctrl_clk_prev = nes_clk;
  end
  assign nes_data = ctrl_sr[0];

  int cyc = 0, overlap_cnt = 0;
  int latch_rises = 0, latch_run = 0, last_latch_len = 0, latch_rise_cyc = 0;
  int clk_rises = 0, clk_falls = 0, clk_run = 0, bad_clk = 0;
  int valid_cnt = 0, valid_cyc = 0, overrun_cnt = 0;
  logic latch_prev = 1'b0, clk_prev = 1'b0;

  always @(negedge clock_10MHz) begin
    cyc++;
    if (nes_latch && nes_clk) overlap_cnt++;
    if (nes_latch && !latch_prev) begin latch_rises++; latch_rise_cyc = cyc; end
    if (nes_latch) latch_run++;
    else if (latch_prev) begin last_latch_len = latch_run; latch_run = 0; end
    if (nes_clk && !clk_prev) clk_rises++;
    if (nes_clk) clk_run++;
    else if (clk_prev) begin
      clk_falls++;
      if (clk_run != 128) bad_clk++;
      clk_run = 0;
    end
    if (buttons_valid) begin valid_cnt++; valid_cyc = cyc; end
    if (poll_overrun) overrun_cnt++;
    latch_prev = nes_latch;
    clk_prev   = nes_clk;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic poll();
    @(negedge clock_10MHz);
    poll_clk = 1'b1;
    repeat (8) @(negedge clock_10MHz);
    poll_clk = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int target, input int limit);
    int n = 0;
    while (valid_cnt < target && n < limit) begin
      @(negedge clock_10MHz);
      n++;
    end
    check(tag, 32'(valid_cnt >= target), 32'd1);
    repeat (2) @(negedge clock_10MHz);
  endtask

  task automatic wait_clk_rises(input string tag, input int target);
    int n = 0;
    while (clk_rises < target && n < 4000) begin
      @(negedge clock_10MHz);
      n++;
    end
    check(tag, 32'(clk_rises >= target), 32'd1);
  endtask

  int v0, o0, l0, f0, b0, r0, v1;

  initial begin
    // Reset state
    repeat (5) @(negedge clock_10MHz);
    check("rst_latch",   32'(nes_latch), 32'd0);
    check("rst_clk",     32'(nes_clk), 32'd0);
    check("rst_buttons", 32'(buttons), 32'd0);
    check("rst_valid",   32'(buttons_valid), 32'd0);
    check("rst_busy",    32'(busy), 32'd0);
    check("rst_overrun", 32'(poll_overrun), 32'd0);
    reset_n = 1'b1;
    repeat (300) @(negedge clock_10MHz);
    check("idle_no_latch", 32'(latch_rises), 32'd0);

    // Single read: A, Select, Right pressed
    pattern = 8'h85;
    v0 = valid_cnt; f0 = clk_falls; b0 = bad_clk;
    poll();
    wait_valid("single_done", v0 + 1, 4000);
    check("single_buttons", 32'(buttons), 32'h85);
    check("single_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("single_latency", 32'(valid_cyc - latch_rise_cyc), 32'd2176);
    check("single_latch_len", 32'(last_latch_len), 32'd128);
    check("single_clk_pulses", 32'(clk_falls - f0), 32'd8);
    check("single_clk_len", 32'(bad_clk - b0), 32'd0);
    check("single_busy_low", 32'(busy), 32'd0);

    // Back-to-back: one extra poll mid-read is queued, not an overrun
    pattern = 8'h3C;
    v0 = valid_cnt; o0 = overrun_cnt;
    poll();
    repeat (1000) @(negedge clock_10MHz);
    poll();
    wait_valid("b2b_first", v0 + 1, 4000);
    v1 = valid_cyc;
    check("b2b_first_buttons", 32'(buttons), 32'h3C);
    pattern = 8'h42;
    wait_valid("b2b_second", v0 + 2, 4000);
    check("b2b_restart_gap", 32'(latch_rise_cyc - v1), 32'd128);
    check("b2b_second_buttons", 32'(buttons), 32'h42);
    check("b2b_no_overrun", 32'(overrun_cnt - o0), 32'd0);

    // Overrun: start, queue one, third rise collapses with a single overrun pulse
    pattern = 8'h81;
    v0 = valid_cnt; o0 = overrun_cnt;
    poll();
    begin
      int n = 0;
      while (!busy && n < 1000) begin @(negedge clock_10MHz); n++; end
      check("ovr_busy", 32'(busy), 32'd1);
    end
    poll();
    repeat (300) @(negedge clock_10MHz);
    poll();
    repeat (5) @(negedge clock_10MHz);
    check("ovr_pulse", 32'(overrun_cnt - o0), 32'd1);
    wait_valid("ovr_second", v0 + 2, 6000);
    repeat (2600) @(negedge clock_10MHz);
    check("ovr_no_third", 32'(valid_cnt - v0), 32'd2);
    check("ovr_overrun_total", 32'(overrun_cnt - o0), 32'd1);
    check("ovr_buttons", 32'(buttons), 32'h81);

    // Reset mid-read during PULSE of bit 3
    pattern = 8'hC3;
    r0 = clk_rises;
    poll();
    wait_clk_rises("rst_reach_bit3", r0 + 4);
    repeat (10) @(negedge clock_10MHz);
    #20 reset_n = 1'b0;
    #1;
    check("mid_rst_latch",   32'(nes_latch), 32'd0);
    check("mid_rst_clk",     32'(nes_clk), 32'd0);
    check("mid_rst_buttons", 32'(buttons), 32'd0);
    check("mid_rst_busy",    32'(busy), 32'd0);
    check("mid_rst_valid",   32'(buttons_valid), 32'd0);
    check("mid_rst_state",   32'(dut.state_q), 32'd0);
    @(negedge clock_10MHz);
    reset_n = 1'b1;
    l0 = latch_rises; v0 = valid_cnt;
    repeat (3000) @(negedge clock_10MHz);
    check("post_rst_quiet_latch", 32'(latch_rises - l0), 32'd0);
    check("post_rst_quiet_valid", 32'(valid_cnt - v0), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    pattern = 8'hFF;
    poll();
    wait_valid("post_rst_read", v0 + 1, 4000);
    check("post_rst_buttons", 32'(buttons), 32'hFF);

    // Stall: freeze step_clk during PULSE of bit 1
    pattern = 8'h5A;
    r0 = clk_rises; v0 = valid_cnt;
    poll();
    wait_clk_rises("stall_reach_bit1", r0 + 2);
    repeat (5) @(negedge clock_10MHz);
    step_run = 1'b0;
    repeat (1000) @(negedge clock_10MHz);
    check("stall_state", 32'(dut.state_q), 32'd3);
    check("stall_latch", 32'(nes_latch), 32'd0);
    check("stall_clk",   32'(nes_clk), 32'd1);
    check("stall_busy",  32'(busy), 32'd1);
    check("stall_no_valid", 32'(valid_cnt - v0), 32'd0);
    step_run = 1'b1;
    wait_valid("stall_resume", v0 + 1, 4000);
    check("stall_buttons", 32'(buttons), 32'h5A);

    // All released
    pattern = 8'h00;
    v0 = valid_cnt;
    poll();
    wait_valid("released_read", v0 + 1, 4000);
    check("released_buttons", 32'(buttons), 32'h00);
    check("released_valid_cnt", 32'(valid_cnt - v0), 32'd1);

    check("latch_clk_overlap", 32'(overlap_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nes_controller_reader.md
Name: nes_controller_reader

Overview:
- Consumes two clock-divider taps and runs the serial read protocol of a standard NES controller.
- The slow tap, nominally clock_80Hz, sets the poll rate. The fast tap, nominally clock_78KHz (12.8 us step), sets the latch/pulse timing.
- Drives the controller's latch and clock pins, samples the controller's serial data line, and presents a registered 8-bit button vector to game logic.
- All logic runs on clock_10MHz. Divider taps are used as enables through edge detection, never as clocks.

Parameters:
- NUM_BITS, 8, number of serial bits read per poll.
- SYNC_STAGES, 2, flip-flop depth of the nes_data synchronizer (minimum 2).

Ports:
- clock_10MHz  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- poll_clk  in  1  divider tap; each rising edge requests one read.
- step_clk  in  1  divider tap; each rising edge advances the protocol one step.
- nes_data  in  1  controller serial data; asynchronous; active-low (0 = pressed).
- nes_latch  out  1  controller latch pin, active-high.
- nes_clk  out  1  controller clock pin, active-high pulse.
- buttons  out  NUM_BITS  1 = pressed. Bit order: 0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
- buttons_valid  out  1  one-cycle pulse when buttons updates.
- busy  out  1  high from leaving IDLE until the read completes.
- poll_overrun  out  1  one-cycle pulse when a poll request is dropped.

Behaviour:
- Reset (async, immediate, also mid-read):
  - All outputs 0, state IDLE, idx 0, shift register 0, pending 0.
  - Edge-detect history registers 0; synchronizer flops 1 (released/idle level).
- Edge detect: poll_edge = poll_clk & ~poll_q; step_edge = step_clk & ~step_q. Both are one-cycle strobes. No synchronizer on the taps, because they are same-domain registered signals.
- Data path: nes_data passes through the SYNC_STAGES synchronizer. The sampled bit is ~data_sync.
- Pending logic:
  - pending_next = (pending & ~consume) | poll_edge.
  - poll_overrun = poll_edge & pending & ~consume (registered, one cycle).
  - consume = IDLE & step_edge & pending.
- FSM. States advance only on step_edge; in every other cycle all registers hold.
  - IDLE: if pending, go to LATCH; nes_latch<=1, busy<=1.
  - LATCH: nes_latch<=0, idx<=0, go to SAMPLE. Latch high time is exactly one step period.
  - SAMPLE: shreg[idx]<=~data_sync, nes_clk<=1, go to PULSE.
  - PULSE: nes_clk<=0.
    - If idx==NUM_BITS-1: buttons<=shreg, buttons_valid<=1, busy<=0, go to IDLE.
    - Else: idx<=idx+1, go to SAMPLE.
- Latency and timing:
  - A read is 1 + 2*NUM_BITS = 17 step edges after the consuming edge.
  - buttons and buttons_valid change on the clock after the 17th step edge following consume.
  - nes_latch and nes_clk are never high simultaneously.
  - buttons holds its value between reads; there is no partial update.
- Boundary cases:
  - A poll_edge while busy with pending=0 is queued; the next read starts at the first step_edge after returning to IDLE.
  - A second poll_edge while pending=1 raises poll_overrun and is otherwise collapsed.
  - poll_edge and consume in the same cycle: the new request stays pending and there is no overrun.
  - A constant step_clk stalls the FSM in its current state with outputs held.
- idx width is $clog2(NUM_BITS).

Decomposition:
- Package nes_pkg holds:
  - typedef enum logic [1:0] {IDLE, LATCH, SAMPLE, PULSE} nes_state_t;
  - button index constants BTN_A..BTN_RIGHT (0..7);
  - NES_NUM_BITS = 8.
- Sub-module rising_edge_detect (clk, reset_n, in, pulse), instantiated twice, for poll_clk and step_clk.
- The synchronizer and FSM stay inline.

Test Plan:
- Single read: drive step_clk with period 128 cycles and one poll_clk rise. nes_data follows the serial pattern for buttons = 8'b1000_0101 (A, Select, Right pressed; data low during those bits). Required: buttons=8'h85 and one buttons_valid pulse 17 step edges after consume; nes_latch high exactly 128 cycles; 8 nes_clk pulses of 128 cycles each.
- Back-to-back: a second poll_clk rise mid-read. Required: poll_overrun stays 0; a second read starts at the first step_edge after busy falls.
- Overrun: three poll rises during one read. Required: exactly one poll_overrun pulse (on the third rise); only one extra read occurs.
- Reset mid-read: assert reset_n low during PULSE of bit 3. Required: outputs immediately 0, buttons=0; after release, no activity until a new poll_clk rise.
- Stall: hold step_clk constant for 1000 cycles mid-read. Required: state, nes_latch, nes_clk and busy unchanged; the read resumes correctly after step_clk resumes.
- All released: nes_data held high throughout a read. Required: buttons=8'h00 with a buttons_valid pulse.
